// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus of the nibble CPU: instruction memory port, IR handshake
// toward decode, and the branch/halt controls coming back from execute.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  halt;
  logic                  halted;

  // Valid/ready: a transfer happens on a rising edge where instr_valid and
  // instr_ready are both high; instruction/instr_pc stay stable while
  // instr_valid is high and instr_ready is low; ready never gates valid.
  modport master (
    output address, instruction, instr_pc, instr_valid, halted,
    input  data, instr_ready, branch_taken, branch_target, halt
  );

  modport slave (
    input  address, instruction, instr_pc, instr_valid, halted,
    output data, instr_ready, branch_taken, branch_target, halt
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch stage: owns the PC, reads the combinational instruction
// memory and holds one fetched byte in the IR until decode accepts it.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus,
  output logic                      state_dbg
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_valid;
  logic                  halted_q;
  logic                  advance;

  // The IR can take a new byte when it is empty or being consumed this edge.
  assign advance = (state == RUN) && (!ir_valid || bus.instr_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_VECTOR;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.halt) begin
            state    <= HALT;
            ir_valid <= 1'b0;
            halted_q <= 1'b1;
          end else if (bus.branch_taken) begin
            // Byte read at the old PC is wrong-path; drop it along with the IR.
            pc       <= bus.branch_target;
            ir_valid <= 1'b0;
          end else if (advance) begin
            ir       <= bus.data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + PC_STEP;
          end
        end
        HALT: begin
          ir_valid <= 1'b0;
          halted_q <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.address     = pc;
  assign bus.instruction = ir;
  assign bus.instr_pc    = ir_pc;
  assign bus.instr_valid = ir_valid;
  assign bus.halted      = halted_q;
  assign state_dbg       = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table for the main
// sequence plus hand-written wrap-around and mid-run reset sequences.
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  logic state_dbg;

  instruction_fetch_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH  (5),
    .DATA_WIDTH  (8),
    .RESET_VECTOR(5'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: mem[0]=0x39, mem[1]=0x00, otherwise 0xA0+i.
  function automatic logic [7:0] mem_val(input int i);
    if (i == 0) return 8'h39;
    if (i == 1) return 8'h00;
    return 8'(8'hA0 + i);
  endfunction

  logic [7:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = mem_val(i);
  assign bus.data = mem[bus.address];

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       br;
    logic [4:0] tgt;
    logic       hlt;
    logic [4:0] e_addr;
    logic       e_valid;
    logic [7:0] e_instr;
    logic [4:0] e_pc;
    logic       e_halted;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rst, logic rdy, logic br, logic [4:0] tgt, logic hlt,
                              logic [4:0] ea, logic ev, logic [7:0] ei, logic [4:0] ep,
                              logic eh);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt; v.hlt = hlt;
    v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_halted = eh;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic rst, input logic rdy, input logic br,
                       input logic [4:0] tgt, input logic hlt);
    reset             = rst;
    bus.instr_ready   = rdy;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt          = hlt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [4:0] ea, input logic ev,
                           input logic [7:0] ei, input logic [4:0] ep, input logic eh);
    check("address", idx, 32'(bus.address), 32'(ea));
    check("instr_valid", idx, 32'(bus.instr_valid), 32'(ev));
    check("instruction", idx, 32'(bus.instruction), 32'(ei));
    check("instr_pc", idx, 32'(bus.instr_pc), 32'(ep));
    check("halted", idx, 32'(bus.halted), 32'(eh));
    check("state_dbg", idx, 32'(state_dbg), 32'(eh));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    //          rst  rdy  br   tgt    hlt  addr   vld  instr  pc     hlt
    vecs.push_back(mk(1, 0, 0, 5'd0,  0, 5'd0,  0, 8'h00, 5'd0,  0)); // reset
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd1,  1, 8'h39, 5'd0,  0)); // first fetch
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd2,  1, 8'h00, 5'd1,  0));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd3,  1, 8'hA2, 5'd2,  0));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd4,  1, 8'hA3, 5'd3,  0));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd5,  1, 8'hA4, 5'd4,  0));
    vecs.push_back(mk(0, 0, 0, 5'd0,  0, 5'd5,  1, 8'hA4, 5'd4,  0)); // stall x3
    vecs.push_back(mk(0, 0, 0, 5'd0,  0, 5'd5,  1, 8'hA4, 5'd4,  0));
    vecs.push_back(mk(0, 0, 0, 5'd0,  0, 5'd5,  1, 8'hA4, 5'd4,  0));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd6,  1, 8'hA5, 5'd5,  0)); // resume
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd7,  1, 8'hA6, 5'd6,  0));
    vecs.push_back(mk(0, 1, 1, 5'd16, 0, 5'd16, 0, 8'hA6, 5'd6,  0)); // branch bubble
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd17, 1, 8'hB0, 5'd16, 0)); // mem[16]
    vecs.push_back(mk(0, 0, 1, 5'd3,  0, 5'd3,  0, 8'hB0, 5'd16, 0)); // branch during stall
    vecs.push_back(mk(0, 0, 0, 5'd0,  0, 5'd4,  1, 8'hA3, 5'd3,  0)); // empty IR refills
    vecs.push_back(mk(0, 1, 1, 5'd30, 0, 5'd30, 0, 8'hA3, 5'd3,  0));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd31, 1, 8'hBE, 5'd30, 0));
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd0,  1, 8'hBF, 5'd31, 0)); // wrap
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd1,  1, 8'h39, 5'd0,  0));
    vecs.push_back(mk(0, 0, 1, 5'd9,  1, 5'd1,  0, 8'h39, 5'd0,  1)); // halt+branch+stall
    vecs.push_back(mk(0, 1, 1, 5'd5,  0, 5'd1,  0, 8'h39, 5'd0,  1)); // ignored in HALT
    vecs.push_back(mk(0, 1, 0, 5'd0,  0, 5'd1,  0, 8'h39, 5'd0,  1));
    vecs.push_back(mk(1, 1, 1, 5'd7,  1, 5'd0,  0, 8'h00, 5'd0,  0)); // reset leaves HALT

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].br, vecs[i].tgt, vecs[i].hlt);
      step();
      check_all(i, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc,
                vecs[i].e_halted);
    end

    // Full sweep at one instruction per cycle, through the 31 -> 0 wrap.
    drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      step();
      check("sweep_pc", 100 + k, 32'(bus.instr_pc), 32'((k - 1) % 32));
      check("sweep_instr", 100 + k, 32'(bus.instruction), 32'(mem_val((k - 1) % 32)));
      check("sweep_valid", 100 + k, 32'(bus.instr_valid), 32'd1);
      check("sweep_addr", 100 + k, 32'(bus.address), 32'(k % 32));
    end

    // Reset mid-operation at PC=12 with a valid IR and decode stalled.
    drive(1'b0, 1'b1, 1'b1, 5'd11, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    check_all(200, 5'd12, 1'b1, 8'hAB, 5'd11, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    check_all(201, 5'd0, 1'b0, 8'h00, 5'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    check_all(202, 5'd1, 1'b1, 8'h39, 5'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential fetch stage of the nibble CPU. Owns the program counter, drives the address of the combinational instruction memory, and latches the returned byte into an instruction register. It presents that byte to the decode/execute stage through a valid/ready handshake. It also accepts branch redirects and a halt request from execute.

## Interface
- ADDR_WIDTH, 5, program counter / instruction memory address width
- DATA_WIDTH, 8, instruction byte width
- RESET_VECTOR, 0, PC value loaded on reset
- clk  input  1  single system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- address  output  ADDR_WIDTH  instruction memory address; combinationally equal to the PC register
- data  input  DATA_WIDTH  instruction memory read data; valid in the same cycle as `address`
- instruction  output  DATA_WIDTH  instruction register (IR)
- instr_pc  output  ADDR_WIDTH  address from which `instruction` was fetched
- instr_valid  output  1  IR holds an instruction not yet consumed
- instr_ready  input  1  decode accepts IR this cycle
- branch_taken  input  1  redirect request from execute, single-cycle pulse
- branch_target  input  ADDR_WIDTH  new PC when `branch_taken`
- halt  input  1  stop fetching; sticky until reset
- halted  output  1  fetch unit is in HALT state

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values: PC=RESET_VECTOR, so `address`=RESET_VECTOR. instruction=0, instr_pc=0, instr_valid=0, halted=0.
- Define advance = RUN and (!instr_valid or instr_ready).
- Evaluate in priority order each rising edge:
  1. reset: apply reset values.
  2. halt in RUN: go to HALT. instr_valid<=0, PC frozen, halted<=1.
  3. branch_taken in RUN: PC<=branch_target, instr_valid<=0. The IR is flushed and `data` for the current address is discarded, even if advance is true.
  4. advance: instruction<=data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
  5. Otherwise (stall: valid and not ready): hold PC, IR, instr_pc and instr_valid.
- PC arithmetic is modulo 2^ADDR_WIDTH. PC=31 increments to 0 with no flag.
- HALT: ignore branch_taken, instr_ready and data. Outputs hold: instr_valid=0, halted=1, `address` frozen. Only reset leaves HALT.
- A transfer occurs on an edge where instr_valid and instr_ready are both 1. Decode must sample `instruction` and `instr_pc` at that edge.
- instr_ready while instr_valid=0 has no effect beyond allowing advance.
- Contents of `data` are never interpreted. Opcode decode belongs to the downstream stage, which asserts branch/halt.

## Timing
- Fetch latency is 1 cycle: the PC on edge N appears as instr_pc with instr_valid=1 after edge N+1.
- First valid instruction: the first edge after reset deasserts loads mem[RESET_VECTOR], so instr_valid=1 one cycle after reset release.
- Throughput: 1 instruction per cycle while instr_ready=1.
- Branch penalty: 1 bubble. On the edge with branch_taken, instr_valid falls to 0. On the next edge, mem[target] is loaded with instr_pc=target.
- Halt takes effect on the edge it is sampled. The IR content at that edge is dropped.
- Reset asserted mid-stall, mid-branch or in HALT: reset values are applied on that edge, regardless of other inputs.
- No combinational path from any input to any output except `address` from the PC register. Note that `address` has no input dependency.

## Test plan
- Reset then free run, instr_ready=1, memory with mem[0]=0x39 and mem[1]=0x00 -> address 0,1,2… each cycle. Cycle 1: instruction=0x39, instr_pc=0. Cycle 2: instruction=0x00, instr_pc=1.
- Stall: deassert instr_ready for 3 cycles while instr_pc=4 -> instruction, instr_pc=4 and address=5 held for 3 cycles. Fetch resumes with instr_pc=5 on the cycle after ready returns.
- Branch: pulse branch_taken with target=0x10 while instr_pc=6 -> next cycle instr_valid=0 and address=0x10. The cycle after: instr_pc=0x10, instruction=mem[16].
- Wrap-around: run to PC=31 -> instr_pc=31 is followed by instr_pc=0 with no gap.
- Simultaneous halt, branch_taken and stall -> HALT entered, halted=1, instr_valid=0, PC unchanged. Later branch/ready pulses are ignored. Reset returns address=0 and halted=0.
- Reset mid-operation at PC=12 with instr_valid=1 -> next edge: address=0, instr_valid=0, instruction=0, instr_pc=0.
